// File: rtl/cmd_frame_parser_if.sv
// Command-path bus of the frame parser: RX FIFO drain side plus the CPU UART TX push side.
// master = parser, slave = switch core / UART side.
interface cmd_frame_parser_if #(
  parameter int CNT_W = 5
);
  logic [7:0]       rec_command;
  logic [CNT_W-1:0] com_count;
  logic             com_pop;
  logic [7:0]       tdr_cpuAB;
  logic             tf_push_cpuAB;

  modport master (
    input  rec_command,
    input  com_count,
    output com_pop,
    output tdr_cpuAB,
    output tf_push_cpuAB
  );

  modport slave (
    output rec_command,
    output com_count,
    input  com_pop,
    input  tdr_cpuAB,
    input  tf_push_cpuAB
  );
endinterface

// File: rtl/cmd_frame_parser.sv
// Validates fixed 8-byte command frames from the command RX FIFO, drives switch-control
// outputs and reset pulses, and answers every frame with a 2-byte ACK/NACK.
module cmd_frame_parser #(
  parameter int CNT_W   = 5,
  parameter int RST_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cmd_frame_parser_if.master    bus,
  output logic                  force_swi,
  output logic                  com_swi,
  output logic                  error,
  output logic                  reset_A,
  output logic                  reset_B
);

  localparam int RC_W = $clog2(RST_CYC + 1);
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RST_CYC);

  localparam logic [7:0] SYNC0 = 8'hEB;
  localparam logic [7:0] SYNC1 = 8'h90;
  localparam logic [7:0] TAIL  = 8'h0D;
  localparam logic [7:0] ACK   = 8'hAA;
  localparam logic [7:0] NACK  = 8'h55;

  localparam logic [7:0] CMD_SW_A  = 8'h01;
  localparam logic [7:0] CMD_SW_B  = 8'h02;
  localparam logic [7:0] CMD_AUTO  = 8'h03;
  localparam logic [7:0] CMD_RST_A = 8'h04;
  localparam logic [7:0] CMD_RST_B = 8'h05;
  localparam logic [7:0] CMD_PING  = 8'h06;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WT,
    CHK,
    RSP0,
    RSP1
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       idx;
  logic [7:0]       frm [8];
  logic             valid_q;
  logic [CNT_W-1:0] count;
  logic [7:0]       sum;
  logic             cmd_ok;
  logic             frame_ok;
  logic [RC_W-1:0]  cnt_a, cnt_b;

  assign count = bus.com_count;

  always_comb begin
    sum      = frm[2] + frm[3] + frm[4] + frm[5];
    cmd_ok   = (frm[2] >= CMD_SW_A) && (frm[2] <= CMD_PING);
    frame_ok = (frm[1] == SYNC1) && (frm[6] == sum) && (frm[7] == TAIL) && cmd_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    bus.com_pop       = 1'b0;
    bus.tf_push_cpuAB = 1'b0;
    bus.tdr_cpuAB     = '0;
    case (state)
      IDLE: begin
        // Only start on a complete frame so reads never stall mid-frame.
        if (count >= CNT_W'(8)) state_nxt = RD;
      end
      RD: begin
        bus.com_pop = (count != '0);
        state_nxt   = WT;
      end
      WT: begin
        if ((idx == 3'd0) && (frm[0] != SYNC0)) state_nxt = IDLE;
        else if (idx == 3'd7)                   state_nxt = CHK;
        else                                    state_nxt = RD;
      end
      CHK: begin
        state_nxt = RSP0;
      end
      RSP0: begin
        bus.tf_push_cpuAB = 1'b1;
        bus.tdr_cpuAB     = valid_q ? ACK : NACK;
        state_nxt         = RSP1;
      end
      RSP1: begin
        bus.tf_push_cpuAB = 1'b1;
        bus.tdr_cpuAB     = frm[2];
        state_nxt         = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      for (int unsigned i = 0; i < 8; i++) frm[i] <= '0;
    end else begin
      if (state == RD) frm[idx] <= bus.rec_command;
      if (state == IDLE)    idx <= '0;
      else if (state == WT) idx <= idx + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      error     <= 1'b0;
      force_swi <= 1'b0;
      com_swi   <= 1'b0;
    end else if (state == CHK) begin
      valid_q <= frame_ok;
      error   <= !frame_ok;
      if (frame_ok) begin
        case (frm[2])
          CMD_SW_A: begin
            force_swi <= 1'b1;
            com_swi   <= 1'b0;
          end
          CMD_SW_B: begin
            force_swi <= 1'b1;
            com_swi   <= 1'b1;
          end
          CMD_AUTO: force_swi <= 1'b0;
          default:  ;
        endcase
      end
    end
  end

  // Reload on a repeated command stretches an active pulse rather than restarting a gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if ((state == CHK) && frame_ok && (frm[2] == CMD_RST_A)) cnt_a <= RC_LOAD;
      else if (cnt_a != '0)                                    cnt_a <= cnt_a - RC_W'(1);
      if ((state == CHK) && frame_ok && (frm[2] == CMD_RST_B)) cnt_b <= RC_LOAD;
      else if (cnt_b != '0)                                    cnt_b <= cnt_b - RC_W'(1);
    end
  end

  always_comb begin
    reset_A = (cnt_a != '0);
    reset_B = (cnt_b != '0);
  end

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    bus.com_pop |-> (bus.com_count != '0));

  a_push_max2: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.tf_push_cpuAB && $past(bus.tf_push_cpuAB) && $past(bus.tf_push_cpuAB, 2)));

endmodule
